dmem_mmio_responder: RTL
========================

# dmem_mmio_responder

Memory-side responder for the core's MEM-stage data port. It decodes each load and store the core issues and serves it from one of two places:

- a word-addressed data RAM;
- a small MMIO block: GPIO output register, free-running 64-bit cycle counter with snapshot, and an 8-bit TX FIFO drained by a valid/ready sink.

Read data is returned combinationally in the same cycle as `mem_re`, because the core registers read data into MEM/WB at the next edge.

## Interface
Parameters:
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; power of two.
- `TX_DEPTH`, 8: TX FIFO depth; power of two, at least 2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-low reset.
- `mem_addr`, in, 32: byte address from EX/MEM ALU result.
- `mem_wdata`, in, 32: store data.
- `mem_we`, in, 1: store strobe, one cycle per store.
- `mem_re`, in, 1: load strobe, one cycle per load.
- `mem_rdata`, out, 32: load data, combinational.
- `gpio_out`, out, 32: GPIO register.
- `tx_valid`, out, 1: FIFO non-empty.
- `tx_data`, out, 8: FIFO head byte.
- `tx_ready`, in, 1: sink accepts the head byte.
- `bus_err`, out, 1: one-cycle pulse flagging a faulting access.

## Operation
Decode, by address:
- `mem_addr[31]`=0 selects RAM, indexed by word `mem_addr[31:2]`.
- `mem_addr[31]`=1 selects MMIO, by offset `mem_addr[7:0]`.

MMIO map:
- 0x00 GPIO_OUT: read/write.
- 0x04 CYCLE_LO: read-only. Returns `counter[31:0]`. A read also latches `counter[63:32]` into the snapshot register at the edge.
- 0x08 CYCLE_HI: read-only. Returns the snapshot register.
- 0x0C TX_DATA: write-only. Pushes `mem_wdata[7:0]`. Reads return 0.
- 0x10 TX_STATUS: read/write. Read layout:
  - bit0 full;
  - bit1 empty;
  - bit2 overflow (sticky);
  - bits[15:8] count, zero-extended.
  - A write with `mem_wdata[2]`=1 clears overflow; other bits are ignored.

Faults. Each of the following pulses `bus_err`; the access has no side effect and `mem_rdata`=0:
- `mem_addr[1:0]`≠0 (misaligned);
- RAM word index ≥ `RAM_WORDS`;
- unmapped MMIO offset, or `mem_addr[30:8]`≠0 in MMIO space;
- a write to CYCLE_LO or CYCLE_HI.

Read-data rules:
- `mem_rdata`=0 whenever `mem_re`=0.
- RAM is read asynchronously. A store is written at the edge.

TX FIFO:
- A push while full is dropped and sets overflow. Exception: a pop in the same cycle frees a slot, so the push is accepted and overflow is not set.
- Pop condition: `tx_valid && tx_ready`.
- A simultaneous push and pop leaves count unchanged.
- `tx_data`=0 when empty.

Counter: 64-bit, +1 every cycle, wraps at 2^64−1 to 0.

Simultaneous `mem_we` and `mem_re` (the core never issues both):
- the store takes effect;
- `mem_rdata` shows pre-store data;
- a CYCLE_LO read side effect still occurs.

## Timing
Reset (rst=0 at an edge):
- counter=0, snapshot=0, `gpio_out`=0;
- FIFO emptied, so `tx_valid`=0 and `tx_data`=0;
- overflow=0, `bus_err`=0.
- RAM contents are not reset.

A reset in the middle of a FIFO drain discards all queued bytes.

Latencies:
- Load: 0 cycles, combinational.
- Store: visible to a load in the next cycle.
- `bus_err`: registered, high for exactly the cycle after the faulting access.
- Push: `tx_valid` rises the cycle after the push edge.
- Status count: reflects pushes and pops as of the last edge.
- Counter: the first cycle after reset release reads CYCLE_LO=0; each later cycle reads one more.

## Structure
- `dmem_pkg` holds:
  - MMIO offset localparams (OFS_GPIO, OFS_CYC_LO, OFS_CYC_HI, OFS_TX_DATA, OFS_TX_STATUS);
  - the STATUS bit indices;
  - the MMIO select bit index (31).
- Sub-module `sync_fifo`, parameterized width/depth:
  - pointers one bit wider than the index;
  - outputs `full`, `empty`, `count`;
  - used for TX.
- Decode, RAM, counter/snapshot and error logic stay in the top module.

## Test plan
- **RAM store/load.** Store 0xDEADBEEF to 0x0000_0010, then load the next cycle → `mem_rdata`=0xDEADBEEF, `bus_err`=0.
- **Cycle snapshot.** Hold rst low, release, then read CYCLE_LO in the 5th cycle after release → 4. Force counter=0x1_FFFF_FFFF (testbench force). Read CYCLE_LO → 0xFFFF_FFFF; next cycle read CYCLE_HI → 1.
- **FIFO fill and overflow.** With `tx_ready`=0, push 0x41..0x49 (9 pushes) → STATUS = full, overflow, count 8. `tx_data`=0x41 throughout.
- **Drain and clear.** Raise `tx_ready` → bytes 0x41..0x48 appear in order over 8 cycles, then `tx_valid`=0. Write STATUS bit2 → STATUS reads 0x0002.
- **Push and pop while full.** Fill the FIFO, then push 0x55 in the same cycle as a pop → count stays 8, overflow stays 0, 0x55 is the last byte drained.
- **Faults.** Each of the following → `bus_err` high one cycle, `mem_rdata`=0, no state change:
  - load at 0x0000_0002;
  - store at 0x8000_0020;
  - load at RAM word `RAM_WORDS`.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data responder.
// MMIO offsets, status bit positions and the register decoder.
package dmem_pkg;

  localparam int MMIO_BIT = 31;

  localparam logic [7:0] OFS_GPIO      = 8'h00;
  localparam logic [7:0] OFS_CYC_LO    = 8'h04;
  localparam logic [7:0] OFS_CYC_HI    = 8'h08;
  localparam logic [7:0] OFS_TX_DATA   = 8'h0C;
  localparam logic [7:0] OFS_TX_STATUS = 8'h10;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 8;

  typedef enum logic [2:0] {
    REG_GPIO,
    REG_CYC_LO,
    REG_CYC_HI,
    REG_TX_DATA,
    REG_TX_STATUS,
    REG_NONE
  } mmio_reg_e;

  function automatic mmio_reg_e decode_ofs(
    input logic [7:0] ofs
  );
    mmio_reg_e r;
    r = REG_NONE;
    unique case (ofs)
      OFS_GPIO:      r = REG_GPIO;
      OFS_CYC_LO:    r = REG_CYC_LO;
      OFS_CYC_HI:    r = REG_CYC_HI;
      OFS_TX_DATA:   r = REG_TX_DATA;
      OFS_TX_STATUS: r = REG_TX_STATUS;
      default:       r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_fifo.sv
// Synchronous FIFO with extra-bit pointers.
// A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-port responder: word RAM plus GPIO, cycle counter and TX FIFO.
// Loads return combinationally; stores and side effects land at the edge.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0] ram [RAM_WORDS];
  logic [63:0] counter;
  logic [31:0] snapshot;
  logic        overflow;

  logic        is_mmio;
  logic        access;
  logic        misaligned;
  logic        ram_oor;
  logic        mmio_bad;
  logic        fault;
  logic        ok;
  mmio_reg_e   reg_sel;
  logic [AW-1:0] ram_idx;

  logic        tx_full;
  logic        tx_empty;
  logic [CW-1:0] tx_count;
  logic        tx_push;
  logic        tx_pop;
  logic        ovf_clr;
  logic        snap_en;
  logic [31:0] status;

  assign access     = mem_we | mem_re;
  assign is_mmio    = mem_addr[MMIO_BIT];
  assign misaligned = |mem_addr[1:0];
  assign ram_oor    = mem_addr[30:2] >= 29'(RAM_WORDS);
  assign reg_sel    = decode_ofs(mem_addr[7:0]);
  assign ram_idx    = mem_addr[AW+1:2];

  // Counter registers are read-only; a store to them is a fault.
  assign mmio_bad = (|mem_addr[30:8]) ||
                    (reg_sel == REG_NONE) ||
                    (mem_we && (reg_sel == REG_CYC_LO ||
                                reg_sel == REG_CYC_HI));

  assign fault = access &&
                 (misaligned || (is_mmio ? mmio_bad : ram_oor));
  assign ok    = !fault;

  assign tx_push = mem_we && ok && is_mmio &&
                   (reg_sel == REG_TX_DATA);
  assign tx_pop  = tx_valid && tx_ready;
  assign ovf_clr = mem_we && ok && is_mmio &&
                   (reg_sel == REG_TX_STATUS) && mem_wdata[2];
  assign snap_en = mem_re && ok && is_mmio &&
                   (reg_sel == REG_CYC_LO);

  assign tx_valid = !tx_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (mem_wdata[7:0]),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_comb begin
    status              = '0;
    status[ST_FULL]     = tx_full;
    status[ST_EMPTY]    = tx_empty;
    status[ST_OVF]      = overflow;
    status[ST_CNT_LO+:8] = 8'(tx_count);
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_re && ok) begin
      unique case (1'b1)
        !is_mmio:
          mem_rdata = ram[ram_idx];
        is_mmio && reg_sel == REG_GPIO:
          mem_rdata = gpio_out;
        is_mmio && reg_sel == REG_CYC_LO:
          mem_rdata = counter[31:0];
        is_mmio && reg_sel == REG_CYC_HI:
          mem_rdata = snapshot;
        is_mmio && reg_sel == REG_TX_STATUS:
          mem_rdata = status;
        default:
          mem_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && ok && !is_mmio) ram[ram_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter  <= '0;
      snapshot <= '0;
      gpio_out <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      counter <= counter + 64'd1;
      bus_err <= fault;
      if (snap_en) snapshot <= counter[63:32];
      if (mem_we && ok && is_mmio && reg_sel == REG_GPIO)
        gpio_out <= mem_wdata;
      if (tx_push && tx_full && !tx_pop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule
